mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single shared memory port.
// One transaction outstanding at a time; data has priority with a starvation guard for fetches.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          owner_d_r, owner_d_s;
  logic [31:0]   addr_r, addr_s;
  logic          we_r, we_s;
  logic [31:0]   wdata_r, wdata_s;
  logic [CW-1:0] starve_r, starve_s;
  logic          m_valid_r, m_valid_s;
  logic          i_gnt_r, i_gnt_s;
  logic          d_gnt_r, d_gnt_s;
  logic          i_rvalid_r, i_rvalid_s;
  logic          d_rvalid_r, d_rvalid_s;
  logic [31:0]   i_rdata_r, i_rdata_s;
  logic [31:0]   d_rdata_r, d_rdata_s;

  // Next-state, arbitration and response capture.
  always_comb begin
    state_s    = state_r;
    owner_d_s  = owner_d_r;
    addr_s     = addr_r;
    we_s       = we_r;
    wdata_s    = wdata_r;
    starve_s   = starve_r;
    m_valid_s  = m_valid_r;
    i_gnt_s    = 1'b0;
    d_gnt_s    = 1'b0;
    i_rvalid_s = 1'b0;
    d_rvalid_s = 1'b0;
    i_rdata_s  = i_rdata_r;
    d_rdata_s  = d_rdata_r;
    case (state_r)
      IDLE: begin
        if (i_req || d_req) begin
          // Fetch wins when alone or once it has lost STARVE_LIMIT times in a row.
          if (i_req && (!d_req || (starve_r >= LIMIT_C))) begin
            owner_d_s = 1'b0;
            addr_s    = i_addr;
            we_s      = 1'b0;
            wdata_s   = 32'h0000_0000;
            starve_s  = '0;
            i_gnt_s   = 1'b1;
          end else begin
            owner_d_s = 1'b1;
            addr_s    = d_addr;
            we_s      = d_we;
            wdata_s   = d_wdata;
            d_gnt_s   = 1'b1;
            if (i_req && (starve_r < LIMIT_C)) begin
              starve_s = starve_r + 1'b1;
            end else begin
              starve_s = starve_r;
            end
          end
          m_valid_s = 1'b1;
          state_s   = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          m_valid_s = 1'b0;
          if (we_r) begin
            d_rvalid_s = 1'b1;
            state_s    = IDLE;
          end else begin
            state_s = WAIT_R;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_R: begin
        if (m_rvalid) begin
          state_s = IDLE;
          if (owner_d_r) begin
            d_rdata_s  = m_rdata;
            d_rvalid_s = 1'b1;
          end else begin
            i_rdata_s  = m_rdata;
            i_rvalid_s = 1'b1;
          end
        end else begin
          state_s = WAIT_R;
        end
      end
      default: begin
        state_s   = IDLE;
        m_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      owner_d_r  <= 1'b0;
      addr_r     <= 32'h0000_0000;
      we_r       <= 1'b0;
      wdata_r    <= 32'h0000_0000;
      starve_r   <= '0;
      m_valid_r  <= 1'b0;
      i_gnt_r    <= 1'b0;
      d_gnt_r    <= 1'b0;
      i_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      i_rdata_r  <= 32'h0000_0000;
      d_rdata_r  <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      owner_d_r  <= owner_d_s;
      addr_r     <= addr_s;
      we_r       <= we_s;
      wdata_r    <= wdata_s;
      starve_r   <= starve_s;
      m_valid_r  <= m_valid_s;
      i_gnt_r    <= i_gnt_s;
      d_gnt_r    <= d_gnt_s;
      i_rvalid_r <= i_rvalid_s;
      d_rvalid_r <= d_rvalid_s;
      i_rdata_r  <= i_rdata_s;
      d_rdata_r  <= d_rdata_s;
    end
  end

  assign i_gnt    = i_gnt_r;
  assign d_gnt    = d_gnt_r;
  assign i_rvalid = i_rvalid_r;
  assign d_rvalid = d_rvalid_r;
  assign i_rdata  = i_rdata_r;
  assign d_rdata  = d_rdata_r;
  assign m_valid  = m_valid_r;
  assign m_we     = we_r;
  assign m_addr   = addr_r;
  assign m_wdata  = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus contention and stall sequences.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied before edge k; expected outputs are those seen after edge k.
  typedef struct {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [133:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [133:0] pack_out(logic ig, logic dg, logic irv, logic drv, logic mv,
                                            logic mwe, logic [31:0] ma, logic [31:0] mwd,
                                            logic [31:0] ird, logic [31:0] drd);
    return {ig, dg, irv, drv, mv, mwe, ma, mwd, ird, drd};
  endfunction

  task automatic add(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                     input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                     input logic mr, input logic mrv, input logic [31:0] mrd,
                     input logic [133:0] e);
    vec_t v;
    v.rst = r; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dwd; v.m_ready = mr; v.m_rvalid = mrv; v.m_rdata = mrd; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_vec(input string name, input logic [133:0] act, input logic [133:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got gnt/rv/mv/we=%b maddr=%h mwdata=%h irdata=%h drdata=%h want gnt/rv/mv/we=%b maddr=%h mwdata=%h irdata=%h drdata=%h",
               name, act[133:128], act[127:96], act[95:64], act[63:32], act[31:0],
               exp[133:128], exp[127:96], exp[95:64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0;
    d_wdata = 32'h0; m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
  endtask

  logic [133:0] z;
  int grants;
  logic prev_i, prev_d;
  logic [31:0] exp_i;

  initial begin
    z = '0;
    idle_inputs();
    //   rst ir ia           dr dw da           dwd            mr mrv mrd            expected
    // single instruction read
    add(1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        z);
    add(0, 1, 32'h100, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        pack_out(1,0,0,0,1,0,32'h100,32'h0,32'h0,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        pack_out(0,0,0,0,0,0,32'h100,32'h0,32'h0,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'hDEADBEEF, pack_out(0,0,1,0,0,0,32'h100,32'h0,32'hDEADBEEF,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        pack_out(0,0,0,0,0,0,32'h100,32'h0,32'hDEADBEEF,32'h0));
    // write held through three stalled cycles
    add(0, 0, 32'h0,   1, 1, 32'h20,  32'h55AA55AA, 0, 0, 32'h0,        pack_out(0,1,0,0,1,1,32'h20,32'h55AA55AA,32'hDEADBEEF,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        pack_out(0,0,0,0,1,1,32'h20,32'h55AA55AA,32'hDEADBEEF,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h99,       pack_out(0,0,0,0,1,1,32'h20,32'h55AA55AA,32'hDEADBEEF,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        pack_out(0,0,0,0,1,1,32'h20,32'h55AA55AA,32'hDEADBEEF,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        pack_out(0,0,0,1,0,1,32'h20,32'h55AA55AA,32'hDEADBEEF,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'h77,       pack_out(0,0,0,0,0,1,32'h20,32'h55AA55AA,32'hDEADBEEF,32'h0));
    // data read interrupted by reset in WAIT_R, then a stale response
    add(0, 0, 32'h0,   1, 0, 32'h44,  32'h0,        0, 0, 32'h0,        pack_out(0,1,0,0,1,0,32'h44,32'h0,32'hDEADBEEF,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        pack_out(0,0,0,0,0,0,32'h44,32'h0,32'hDEADBEEF,32'h0));
    add(1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        z);
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'h12345678, z);
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        z);
    // request held through reset, then back-to-back I read and D read
    add(1, 1, 32'h200, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        z);
    add(0, 1, 32'h200, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        pack_out(1,0,0,0,1,0,32'h200,32'h0,32'h0,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        pack_out(0,0,0,0,0,0,32'h200,32'h0,32'h0,32'h0));
    add(0, 0, 32'h0,   1, 0, 32'h300, 32'h0,        1, 1, 32'hCAFEF00D, pack_out(0,0,1,0,0,0,32'h200,32'h0,32'hCAFEF00D,32'h0));
    add(0, 0, 32'h0,   1, 0, 32'h300, 32'h0,        1, 0, 32'h0,        pack_out(0,1,0,0,1,0,32'h300,32'h0,32'hCAFEF00D,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        pack_out(0,0,0,0,0,0,32'h300,32'h0,32'hCAFEF00D,32'h0));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 1, 32'h0BADF00D, pack_out(0,0,0,1,0,0,32'h300,32'h0,32'hCAFEF00D,32'h0BADF00D));
    add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        pack_out(0,0,0,0,0,0,32'h300,32'h0,32'hCAFEF00D,32'h0BADF00D));

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; i_req = vecs[k].i_req; i_addr = vecs[k].i_addr;
      d_req = vecs[k].d_req; d_we = vecs[k].d_we; d_addr = vecs[k].d_addr;
      d_wdata = vecs[k].d_wdata; m_ready = vecs[k].m_ready;
      m_rvalid = vecs[k].m_rvalid; m_rdata = vecs[k].m_rdata;
      tick();
      check_vec($sformatf("vec%0d", k),
                pack_out(i_gnt, d_gnt, i_rvalid, d_rvalid, m_valid, m_we, m_addr, m_wdata, i_rdata, d_rdata),
                vecs[k].exp);
    end

    // Contention: both ports request continuously; expect D,D,D,D,I repeating.
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0; i_req = 1'b1; i_addr = 32'hA0; d_req = 1'b1; d_addr = 32'hB0;
    m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h5;
    grants = 0; prev_i = 1'b0; prev_d = 1'b0;
    for (int c = 0; c < 200 && grants < 10; c++) begin
      tick();
      if (i_gnt || d_gnt) begin
        exp_i = (grants % 5 == 4) ? 32'd1 : 32'd0;
        check32($sformatf("cont_winner%0d", grants), {30'd0, i_gnt, d_gnt}, {30'd0, exp_i[0], ~exp_i[0]});
        check32("cont_gnt_width", {30'd0, i_gnt & prev_i, d_gnt & prev_d}, 32'd0);
        grants++;
      end else begin
        grants = grants;
      end
      prev_i = i_gnt; prev_d = d_gnt;
    end
    check32("cont_grants", grants, 32'd10);

    // Stall: long-stalled D write, I request arrives mid-stall and waits.
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h11;
    tick();
    check32("stall_dgnt", {31'd0, d_gnt}, 32'd1);
    d_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        i_req = 1'b1; i_addr = 32'h80;
      end else begin
        i_req = i_req;
      end
      tick();
      check32($sformatf("stall_hold%0d", c), {i_gnt, m_valid, m_we, m_addr[28:0]}, {1'b0, 1'b1, 1'b1, 29'h40});
    end
    m_ready = 1'b1;
    tick();
    check32("stall_accept", {29'd0, m_valid, d_rvalid, i_gnt}, {29'd0, 1'b0, 1'b1, 1'b0});
    tick();
    check32("stall_igrant", {i_gnt, m_valid, m_we, m_addr[28:0]}, {1'b1, 1'b1, 1'b0, 29'h80});
    i_req = 1'b0;
    tick();
    m_rvalid = 1'b1; m_rdata = 32'h77;
    tick();
    check32("stall_irdata", i_rdata, 32'h77);
    check32("stall_irvalid", {30'd0, i_rvalid, d_rvalid}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
